// File: rtl/owt_pkg.sv
// owt_pkg: shared FSM state type and default parameters for the one-wire frame decoder
package owt_pkg;
  typedef enum logic [1:0] {HUNT, DATA, PAR} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_HDR_W = 4;
  localparam logic [3:0] DEF_HDR_PAT = 4'b1011;
  localparam int DEF_TMO_W = 10;
  localparam int DEF_TMO_TH = 512;
endpackage

// File: rtl/owt_tmo_cnt.sv
// owt_tmo_cnt: counts consecutive idle cycles mid-frame and flags the cycle that reaches the threshold
module owt_tmo_cnt #(
  parameter int TMO_W = 10,
  parameter logic [TMO_W-1:0] TMO_TH = TMO_W'(512)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_bit_vld,
  output logic o_expire
);
  logic [TMO_W-1:0] r_cnt;
  assign o_expire = i_run && !i_bit_vld && (r_cnt == TMO_TH - 1'b1);
  // idle counter: cleared by any bit, by leaving the frame and by its own expiry
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_cnt <= '0;
    else r_cnt <= (!i_run || i_bit_vld || o_expire) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/owt_frame_decode.sv
// owt_frame_decode: header hunt, payload + even parity check, one-deep output buffer; mid-frame timeout with OWT_FRAME_DECODE_TMO_EN
module owt_frame_decode
  import owt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int HDR_W = DEF_HDR_W,
  parameter logic [HDR_W-1:0] HDR_PAT = HDR_W'(DEF_HDR_PAT),
  parameter int TMO_W = DEF_TMO_W,
  parameter logic [TMO_W-1:0] TMO_TH = TMO_W'(DEF_TMO_TH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_bit_vld,
  input  logic              i_bit_data,
  input  logic              i_frm_rdy,
  output logic              o_frm_vld,
  output logic [DATA_W-1:0] o_frm_data,
  output logic              o_frm_err,
  output logic              o_ovf,
  output logic              o_tmo
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int FW = $clog2(HDR_W + 1);
  state_t r_state, w_next;
  logic [HDR_W-2:0] r_hunt;
  logic [FW-1:0] r_fill;
  logic [CW-1:0] r_cnt;
  logic [DATA_W-1:0] r_pay, r_data;
  logic r_vld, r_err, r_ovf, r_tmo;
  logic [HDR_W-1:0] w_cand;
  logic w_match, w_last, w_par, w_odd, w_good, w_bad, w_expire;
  assign w_cand = {r_hunt, i_bit_data};
  assign w_match = (r_state == HUNT) && i_bit_vld && (32'(r_fill) + 1 >= HDR_W) && (w_cand == HDR_PAT);
  assign w_last = r_cnt == CW'(DATA_W - 1);
  assign w_par = (r_state == PAR) && i_bit_vld;
  assign w_odd = ^r_pay ^ i_bit_data;
  assign w_good = w_par && !w_odd;
  assign w_bad = w_par && w_odd;
`ifdef OWT_FRAME_DECODE_TMO_EN
  owt_tmo_cnt #(.TMO_W(TMO_W), .TMO_TH(TMO_TH)) u_tmo (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_run(r_state != HUNT),
    .i_bit_vld(i_bit_vld),
    .o_expire(w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif
  // state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= HUNT;
    else r_state <= w_next;
  // next state: only accepted bits advance; timeout returns to hunting
  always_comb begin
    w_next = r_state;
    if (w_expire) w_next = HUNT;
    else if (i_bit_vld)
      w_next = (r_state == HUNT) ? (w_match ? DATA : HUNT) : (r_state == DATA) ? (w_last ? PAR : DATA) : HUNT;
  end
  // hunt shifter, payload shifter, bit counter and event pulses
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_hunt <= '0;
      r_fill <= '0;
      r_cnt <= '0;
      r_pay <= '0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      r_err <= w_bad;
      r_ovf <= w_good && r_vld && !i_frm_rdy;
      r_tmo <= w_expire;
      if (r_state == HUNT && i_bit_vld) begin
        r_hunt <= w_match ? '0 : w_cand[HDR_W-2:0];
        r_fill <= w_match ? '0 : (r_fill == FW'(HDR_W)) ? r_fill : r_fill + 1'b1;
        r_cnt <= '0;
      end
      if (r_state == DATA && i_bit_vld) begin
        r_pay <= {r_pay[DATA_W-2:0], i_bit_data};
        r_cnt <= r_cnt + 1'b1;
      end
    end
  // one-deep output buffer: load a good frame if empty or draining, else it is dropped
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_vld <= 1'b0;
      r_data <= '0;
    end else if (w_good && (!r_vld || i_frm_rdy)) begin
      r_vld <= 1'b1;
      r_data <= r_pay;
    end else if (i_frm_rdy) r_vld <= 1'b0;
  assign o_frm_vld = r_vld;
  assign o_frm_data = r_data;
  assign o_frm_err = r_err;
  assign o_ovf = r_ovf;
  assign o_tmo = r_tmo;
endmodule

// File: tb/tb_owt_frame_decode.sv
// tb_owt_frame_decode: randomized + directed stimulus, bit-stream reference model, cycle-stamped scoreboard
module tb_owt_frame_decode;
`ifdef OWT_FRAME_DECODE_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TH = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic i_bit_vld = 1'b0, i_bit_data = 1'b0, i_frm_rdy = 1'b0;
  logic o_frm_vld, o_frm_err, o_ovf, o_tmo;
  logic [7:0] o_frm_data;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {logic [7:0] data; int cyc;} frm_t;
  frm_t q_frm[$];
  int q_err[$], q_ovf[$], q_tmo[$];
  bit hunting = 1'b1, full = 1'b0, g_rdy = 1'b1, g_rand = 1'b0, g_gap = 1'b0;
  bit hist[$], coll[$];
  int idle = 0;
  owt_frame_decode #(.DATA_W(8), .HDR_W(4), .HDR_PAT(4'b1011), .TMO_W(10), .TMO_TH(10'd16)) dut (
    .i_clk(clk), .i_rst(rst), .i_bit_vld(i_bit_vld), .i_bit_data(i_bit_data), .i_frm_rdy(i_frm_rdy),
    .o_frm_vld(o_frm_vld), .o_frm_data(o_frm_data), .o_frm_err(o_frm_err), .o_ovf(o_ovf), .o_tmo(o_tmo));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // reference model: consumes one cycle of line activity, predicts output events and their cycle
  task automatic model_step(bit v, bit b, bit r, int c);
    logic [3:0] h;
    logic [7:0] p;
    bit load = 1'b0;
    if (v) begin
      idle = 0;
      if (hunting) begin
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
        if (hist.size() >= 4) begin
          h = '0;
          for (int i = 0; i < 4; i++) h = {h[2:0], hist[hist.size() - 4 + i]};
          if (h == 4'b1011) begin
            hunting = 1'b0;
            hist.delete();
            coll.delete();
          end
        end
      end else begin
        coll.push_back(b);
        if (coll.size() == 9) begin
          p = '0;
          for (int i = 0; i < 8; i++) p = {p[6:0], coll[i]};
          if ((^p ^ coll[8]) != 1'b0) q_err.push_back(c + 1);
          else if (!full || r) begin
            load = 1'b1;
            full = 1'b1;
            q_frm.push_back('{p, c + 1});
          end else q_ovf.push_back(c + 1);
          hunting = 1'b1;
        end
      end
    end else if (!hunting && TMO_EN) begin
      idle++;
      if (idle == TH) begin
        q_tmo.push_back(c + 1);
        hunting = 1'b1;
        idle = 0;
      end
    end
    if (!load && r) full = 1'b0;
  endtask
  task automatic step(bit v, bit b);
    bit r;
    @(posedge clk);
    #2;
    r = g_rand ? 1'($urandom_range(0, 1)) : g_rdy;
    i_bit_vld = v;
    i_bit_data = b;
    i_frm_rdy = r;
    model_step(v, b, r, cyc);
  endtask
  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask
  task automatic send_bits(logic [31:0] v, int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, v[i]);
      if (g_gap) idle_n(($urandom_range(0, 99) < 3) ? TH + 1 : $urandom_range(0, 1));
    end
  endtask
  task automatic frame(logic [7:0] d, bit bad);
    send_bits(32'hB, 4);
    send_bits({24'h0, d}, 8);
    send_bits({31'h0, ^d ^ bad}, 1);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    i_bit_vld = 1'b0;
    #1;
    chk("rst_vld", o_frm_vld, 0);
    chk("rst_data", o_frm_data, 0);
    chk("rst_err", o_frm_err, 0);
    chk("rst_ovf", o_ovf, 0);
    chk("rst_tmo", o_tmo, 0);
    hunting = 1'b1; full = 1'b0; idle = 0;
    hist.delete(); coll.delete();
    q_frm.delete(); q_err.delete(); q_ovf.delete(); q_tmo.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask
  // monitor: pops the scoreboard whenever the DUT presents a frame or a pulse
  initial begin
    bit p_vld = 1'b0, p_hs = 1'b0;
    logic [7:0] cur = '0;
    frm_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_vld = 1'b0;
        p_hs = 1'b0;
      end else begin
        if (o_frm_vld) begin
          if (!p_vld || p_hs) begin
            if (q_frm.size() == 0) chk("frame_unexpected", 1, 0);
            else begin
              e = q_frm.pop_front();
              chk("frame_data", o_frm_data, e.data);
              chk("frame_cycle", cyc, e.cyc);
            end
            cur = o_frm_data;
          end else chk("frame_hold", o_frm_data, cur);
        end
        if (o_frm_err) chk("err_cycle", cyc, (q_err.size() != 0) ? q_err.pop_front() : -1);
        if (o_ovf) chk("ovf_cycle", cyc, (q_ovf.size() != 0) ? q_ovf.pop_front() : -1);
        if (o_tmo) chk("tmo_cycle", cyc, (q_tmo.size() != 0) ? q_tmo.pop_front() : -1);
        p_vld = o_frm_vld;
        p_hs = o_frm_vld && i_frm_rdy;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("init_vld", o_frm_vld, 0);
    chk("init_data", o_frm_data, 0);
    chk("init_pulses", {o_frm_err, o_ovf, o_tmo}, 0);
    rst = 1'b0;
    g_rdy = 1'b1;
    frame(8'hA5, 1'b0);
    idle_n(3);
    frame(8'hA5, 1'b1);
    idle_n(3);
    send_bits(32'hB, 4);
    send_bits(32'h5, 3);
    idle_n(TH);
    frame(8'h3C, 1'b0);
    idle_n(3);
    g_rdy = 1'b0;
    frame(8'hA5, 1'b0);
    frame(8'h5A, 1'b0);
    idle_n(3);
    g_rdy = 1'b1;
    idle_n(3);
    send_bits(32'h1B, 6);
    send_bits(32'hA5, 8);
    send_bits(32'h0, 1);
    idle_n(3);
    g_rdy = 1'b0;
    frame(8'hC3, 1'b0);
    send_bits(32'hB, 4);
    send_bits(32'h6, 3);
    do_reset();
    g_rdy = 1'b1;
    frame(8'h3C, 1'b0);
    idle_n(3);
    g_rand = 1'b1;
    g_gap = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send_bits($urandom, $urandom_range(0, 5));
      frame(8'($urandom), $urandom_range(0, 99) < 20);
    end
    g_rand = 1'b0;
    g_gap = 1'b0;
    g_rdy = 1'b1;
    idle_n(TH + 4);
    chk("frm_left", q_frm.size(), 0);
    chk("err_left", q_err.size(), 0);
    chk("ovf_left", q_ovf.size(), 0);
    chk("tmo_left", q_tmo.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/owt_frame_decode.md
OWT_FRAME_DECODE -- requirements
Module: owt_frame_decode

Interface
REQ-001 Parameter DATA_W, default 16, frame payload width in bits.
REQ-002 Parameter HDR_W, default 4, header length in bits.
REQ-003 Parameter HDR_PAT, default HDR_W'(4'b1011), header pattern; MSB is received first.
REQ-004 Parameter TMO_W, default 10, timeout counter width.
REQ-005 Parameter TMO_TH, default TMO_W'(512), number of idle cycles mid-frame before abort.
REQ-006 i_clk  in  1  sole clock; all state updates on posedge.
REQ-007 i_rst  in  1  reset, asynchronous, active-high.
REQ-008 i_bit_vld  in  1  one-cycle strobe: a decoded line bit is present.
REQ-009 i_bit_data  in  1  value of the decoded bit; qualified by i_bit_vld.
REQ-010 i_frm_rdy  in  1  consumer accepts the held frame.
REQ-011 o_frm_vld  out  1  frame held in output buffer.
REQ-012 o_frm_data  out  DATA_W  payload of the held frame.
REQ-013 o_frm_err  out  1  one-cycle pulse: parity error, frame discarded.
REQ-014 o_ovf  out  1  one-cycle pulse: good frame dropped because the buffer was full.
REQ-015 o_tmo  out  1  one-cycle pulse: mid-frame timeout abort.

Function
REQ-016 Frame format: HDR_W header bits, then DATA_W data bits MSB-first, then 1 even-parity bit.
REQ-017 State machine has three states: HUNT (reset state), DATA, PAR.
REQ-018 HUNT: shift accepted bits into a hunt register with a fill count saturating at HDR_W; match = fill count + 1 >= HDR_W and {last HDR_W-1 bits, current bit} == HDR_PAT.
REQ-019 On match: go to DATA, clear the data bit counter, clear the hunt register and its fill count.
REQ-020 Without a match, HUNT slides one bit per accepted bit; overlapping header candidates are detected.
REQ-021 DATA: shift each accepted bit into the payload register; after the DATA_W-th bit, go to PAR.
REQ-022 PAR: on the accepted bit, evaluate XOR of payload and parity bit; 0 = good, 1 = error; always return to HUNT.
REQ-023 Good frame with buffer empty, or with i_frm_rdy=1 in the same cycle: o_frm_vld=1 and o_frm_data loaded on the next edge (latency 1 cycle after the parity bit).
REQ-024 Good frame with buffer full and i_frm_rdy=0: frame dropped, o_ovf pulses next cycle, held data unchanged.
REQ-025 Error frame: o_frm_err pulses next cycle; buffer untouched.
REQ-026 o_frm_vld clears on the edge after i_frm_rdy=1, unless a new good frame is loaded in the same cycle.
REQ-027 o_frm_data is held stable while o_frm_vld=1 and it is not being replaced.
REQ-028 Cycles with i_bit_vld=0 do not advance the FSM.

Reset
REQ-029 i_rst=1 asynchronously forces: state HUNT; hunt, payload and counters to 0; o_frm_vld, o_frm_data, o_frm_err, o_ovf, o_tmo to 0.
REQ-030 Reset mid-frame discards the partial frame and any held frame; no pulse is generated on release.

Configuration
REQ-031 Macro OWT_FRAME_DECODE_TMO_EN defined: in DATA or PAR, count consecutive cycles with i_bit_vld=0.
- Counter clears on any accepted bit and on entry to HUNT.
- When the counter reaches TMO_TH: go to HUNT, discard the partial frame, pulse o_tmo next cycle.
- A bit arriving in the cycle the threshold would be reached wins; no timeout occurs.
REQ-032 Macro undefined: no counter logic, o_tmo tied 0, DATA/PAR wait indefinitely.

Structure
REQ-033 Shared package owt_pkg holds the FSM state enum (HUNT/DATA/PAR) and default parameter constants.
REQ-034 The timeout counter is one sub-module, owt_tmo_cnt, instantiated only when OWT_FRAME_DECODE_TMO_EN is defined.

Verification
Settings: DATA_W=8, HDR_W=4, HDR_PAT=4'b1011, TMO_TH=16, macro defined.
REQ-035 Bits 1011, 10100101, parity 0, with i_frm_rdy=1 -> o_frm_vld=1 one cycle after the parity strobe, o_frm_data=8'hA5, then clears.
REQ-036 Same frame with parity 1 -> o_frm_err single pulse; o_frm_vld stays 0.
REQ-037 Header plus 3 data bits, then 16 idle cycles -> o_tmo pulse, state HUNT; the next full 8'h3C frame decodes correctly.
REQ-038 i_frm_rdy=0, frames 8'hA5 then 8'h5A -> o_ovf pulse after the second frame, o_frm_data stays 8'hA5; raising i_frm_rdy clears o_frm_vld.
REQ-039 Prefix 0,1,1,0,1,1 then 8'hA5 and parity 0 -> header found at the overlapping position, o_frm_data=8'hA5.
REQ-040 i_rst pulsed mid-DATA -> all outputs 0 immediately; the following full frame decodes.
